muldiv_issue: RTL and testbench
===============================

Name: muldiv_issue

Overview:
- EX-stage initiator for the RV32M multiply/divide unit. It accepts one M-extension instruction from the pipeline, latches its operands and drives the unit's start/opcode/operand handshake.
- Stalls the pipeline until the unit returns ready, then presents a one-cycle register writeback.
- Handles flushes while the unit is mid-operation. The unit cannot be aborted, so the issuer drains the in-flight operation and discards its result.

Parameters:
- TIMEOUT_CYCLES, 64: maximum cycles spent in WAIT/DRAIN before the watchdog fires (only used with MULDIV_TIMEOUT_EN).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  M-extension instruction present in EX
- in_funct3  in  3  RV32M funct3 (000 MUL … 111 REMU)
- in_rs1_val  in  32  operand A
- in_rs2_val  in  32  operand B
- in_rd  in  5  destination register
- flush  in  1  kill the instruction currently in EX
- stall  out  1  hold the pipeline front end
- md_start  out  1  one-cycle start pulse to the unit
- md_opcode  out  3  opcode to the unit (= latched funct3)
- md_rs1  out  32  latched operand A
- md_rs2  out  32  latched operand B
- md_busy  in  1  unit busy
- md_ready  in  1  unit one-cycle result-valid pulse
- md_result  in  32  unit result
- wb_valid  out  1  writeback strobe
- wb_rd  out  5  writeback register
- wb_data  out  32  writeback data
- err  out  1  sticky watchdog error

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE.
  - All outputs and latched registers are 0, kill flag cleared.
  - Reset mid-operation returns to IDLE in one cycle. The top level resets the unit in the same cycle.
- States: IDLE, ISSUE, WAIT, WB, DRAIN.
- IDLE:
  - Accept when in_valid & !flush & !md_busy: latch funct3, rs1, rs2, rd into md_opcode/md_rs1/md_rs2/rd_q, then go to ISSUE.
  - in_valid & md_busy: no accept, stay in IDLE.
  - flush in IDLE: no accept.
- ISSUE: md_start=1 for exactly this cycle.
  - flush=1: go to DRAIN.
  - Otherwise: go to WAIT.
- WAIT: md_start=0.
  - md_ready=1 and flush=0: capture md_result into wb_data and rd_q into wb_rd, go to WB.
  - flush=1 and md_ready=0: go to DRAIN.
  - flush=1 and md_ready=1: discard the result, go to IDLE.
- WB:
  - wb_valid=1 for this cycle only. Forced to 0 if rd_q==0 or flush=1.
  - Always go to IDLE next cycle.
- DRAIN:
  - Wait for md_ready. The result is discarded and wb_valid stays 0.
  - On md_ready, go to IDLE.
- stall (combinational):
  - 1 in ISSUE and WAIT.
  - 1 in IDLE when in_valid & !flush.
  - 1 in DRAIN when in_valid.
  - 0 in WB, so the completed instruction leaves EX at the end of the WB cycle.
- Operand stability: md_opcode, md_rs1 and md_rs2 stay constant from ISSUE until the cycle md_ready is sampled, including through DRAIN. Input changes after accept are ignored.
- Latency from the accept edge:
  - MUL/MULH*: md_start at T1, md_ready at T2, wb_valid at T3.
  - DIV/REM: md_start at T1; wb_valid one cycle after md_ready (about 36 cycles after start).
- Back-to-back operation: a new instruction can be accepted in the IDLE cycle immediately after WB or DRAIN.
- md_ready outside WAIT/DRAIN is ignored.
- wb_data and wb_rd hold their last value when wb_valid=0.

Optional Feature:
- Macro: MULDIV_TIMEOUT_EN.
- When defined:
  - A counter, cleared on entering ISSUE, increments in WAIT/DRAIN.
  - At count == TIMEOUT_CYCLES without md_ready: err is set to 1 (sticky until reset), go to IDLE, wb_valid stays 0, stall releases.
- When undefined:
  - No counter is built and err is tied to 0.
  - WAIT/DRAIN wait indefinitely.

Test Plan:
- MUL, rs1=7, rs2=0xFFFFFFFD, rd=5 → md_start at T1; wb_valid=1, wb_rd=5, wb_data=0xFFFFFFEB at T3; stall high T0–T2, low at T3.
- DIV, rs1=0xFFFFFFEC (−20), rs2=3, rd=9 → stall held through the whole divide; a single wb_valid with wb_data=0xFFFFFFFA one cycle after md_ready; md_rs1/md_rs2 stable throughout.
- DIVU, rs1=0x1234, rs2=0 → wb_data=0xFFFFFFFF. Then REMU with the same operands → wb_data=0x1234.
- DIV issued, flush 5 cycles into WAIT, then MUL (rs1=3, rs2=4) presented:
  - No wb_valid for the DIV.
  - stall=1 with MUL present during DRAIN.
  - MUL md_start only after the DIV's md_ready.
  - MUL writeback 0x0000000C.
- MULHU, rs1=rs2=0xFFFFFFFF, rd=0 → unit completes, wb_valid stays 0. Reset asserted mid-DIV → all outputs 0 and IDLE next cycle.
- With MULDIV_TIMEOUT_EN and a stub unit that never asserts md_ready, issue DIV → err=1 exactly 64 cycles after entering WAIT, stall=0, no wb_valid, err held until rst_n=0.

Source files
------------

// File: rtl/muldiv_issue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | muldiv_issue : EX-stage issuer for the RV32M multiply/divide unit.          |
// | Optional watchdog: define MULDIV_TIMEOUT_EN.  Rev 1.0                       |
// +----------------------------------------------------------------------------+
module muldiv_issue #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_rs1_val,
  input  logic [31:0] in_rs2_val,
  input  logic [4:0]  in_rd,
  input  logic        flush,
  output logic        stall,
  output logic        md_start,
  output logic [2:0]  md_opcode,
  output logic [31:0] md_rs1,
  output logic [31:0] md_rs2,
  input  logic        md_busy,
  input  logic        md_ready,
  input  logic [31:0] md_result,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        err
);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_ISSUE = 3'd1;
  localparam logic [2:0] c_WAIT  = 3'd2;
  localparam logic [2:0] c_WB    = 3'd3;
  localparam logic [2:0] c_DRAIN = 3'd4;

  logic [2:0]  r_state;
  logic [2:0]  w_next;
  logic [2:0]  r_opcode;
  logic [31:0] r_rs1;
  logic [31:0] r_rs2;
  logic [4:0]  r_rd;
  logic [4:0]  r_wb_rd;
  logic [31:0] r_wb_data;
  logic        w_accept;
  logic        w_capture;
  logic        w_timeout;

  assign w_accept  = (r_state == c_IDLE) && in_valid && !flush && !md_busy;
  assign w_capture = (r_state == c_WAIT) && md_ready && !flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE:  if (w_accept) w_next = c_ISSUE;
      c_ISSUE: w_next = flush ? c_DRAIN : c_WAIT;
      c_WAIT: begin
        // A result arriving together with a flush is simply dropped.
        if (md_ready)       w_next = flush ? c_IDLE : c_WB;
        else if (w_timeout) w_next = c_IDLE;
        else if (flush)     w_next = c_DRAIN;
      end
      c_WB:    w_next = c_IDLE;
      c_DRAIN: if (md_ready || w_timeout) w_next = c_IDLE;
      default: w_next = c_IDLE;
    endcase
  end

  always_comb begin
    md_start = 1'b0;
    stall    = 1'b0;
    wb_valid = 1'b0;
    case (r_state)
      c_IDLE:  stall = in_valid && !flush;
      c_ISSUE: begin
        md_start = 1'b1;
        stall    = 1'b1;
      end
      c_WAIT:  stall = 1'b1;
      c_WB:    wb_valid = (r_rd != 5'd0) && !flush;
      c_DRAIN: stall = in_valid;
      default: stall = 1'b0;
    endcase
  end

  // Operands are only loaded on accept, so they stay frozen through WAIT/DRAIN.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_opcode  <= 3'd0;
      r_rs1     <= 32'd0;
      r_rs2     <= 32'd0;
      r_rd      <= 5'd0;
      r_wb_rd   <= 5'd0;
      r_wb_data <= 32'd0;
    end else begin
      if (w_accept) begin
        r_opcode <= in_funct3;
        r_rs1    <= in_rs1_val;
        r_rs2    <= in_rs2_val;
        r_rd     <= in_rd;
      end
      if (w_capture) begin
        r_wb_rd   <= r_rd;
        r_wb_data <= md_result;
      end
    end
  end

  assign md_opcode = r_opcode;
  assign md_rs1    = r_rs1;
  assign md_rs2    = r_rs2;
  assign wb_rd     = r_wb_rd;
  assign wb_data   = r_wb_data;

`ifdef MULDIV_TIMEOUT_EN
  localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [c_CNT_W-1:0] r_cnt;
  logic               r_err;
  logic               w_waiting;

  assign w_waiting = (r_state == c_WAIT) || (r_state == c_DRAIN);
  // Fires on the TIMEOUT_CYCLES-th cycle spent waiting (count starts at 0).
  assign w_timeout = w_waiting && !md_ready &&
                     (r_cnt == c_CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt <= '0;
      end else if (w_waiting && !w_timeout) begin
        r_cnt <= r_cnt + c_CNT_W'(1);
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  assign err = r_err;
`else
  logic [31:0] w_unused_timeout;

  assign w_unused_timeout = 32'(TIMEOUT_CYCLES);
  assign w_timeout        = 1'b0;
  assign err              = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_muldiv_issue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_muldiv_issue : scoreboard bench for muldiv_issue with a behavioural      |
// | multiply/divide unit.  Rev 1.0                                              |
// +----------------------------------------------------------------------------+
module tb_muldiv_issue;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [2:0]  in_funct3;
  logic [31:0] in_rs1_val;
  logic [31:0] in_rs2_val;
  logic [4:0]  in_rd;
  logic        flush;
  logic        stall;
  logic        md_start;
  logic [2:0]  md_opcode;
  logic [31:0] md_rs1;
  logic [31:0] md_rs2;
  logic        md_busy;
  logic        md_ready;
  logic [31:0] md_result;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        err;

  logic        m_busy;
  logic        busy_force;
  logic        unit_hang;
  int          n_checks;
  int          n_errors;
  logic [36:0] exp_q[$];

  assign md_busy = m_busy | busy_force;

  muldiv_issue #(.TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_funct3(in_funct3),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_rd(in_rd),
    .flush(flush), .stall(stall), .md_start(md_start), .md_opcode(md_opcode),
    .md_rs1(md_rs1), .md_rs2(md_rs2), .md_busy(md_busy), .md_ready(md_ready),
    .md_result(md_result), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RV32M arithmetic from the ISA definition.
  function automatic logic [31:0] rv32m(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa;
    logic [63:0] sb;
    logic [63:0] ua;
    logic [63:0] ub;
    logic [63:0] p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    p  = 64'd0;
    case (f)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return $signed(a) / $signed(b);
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Behavioural unit: 1-cycle multiplies, 34-cycle divides.
  initial begin
    logic        rs;
    logic        st;
    logic        pend;
    int          rem;
    logic [2:0]  op_l;
    logic [31:0] a_l;
    logic [31:0] b_l;
    logic [2:0]  op_s;
    logic [31:0] a_s;
    logic [31:0] b_s;
    m_busy = 1'b0; md_ready = 1'b0; md_result = 32'd0;
    pend = 1'b0; rem = 0; op_l = 3'd0; a_l = 32'd0; b_l = 32'd0;
    forever begin
      @(posedge clk);
      rs = rst_n; st = md_start; op_s = md_opcode; a_s = md_rs1; b_s = md_rs2;
      #1;
      md_ready = 1'b0;
      if (!rs) begin
        pend = 1'b0;
        m_busy = 1'b0;
      end else begin
        if (st) begin
          chk("start_while_unit_busy", {31'd0, pend}, 32'd0);
          pend = 1'b1; m_busy = 1'b1;
          op_l = op_s; a_l = a_s; b_l = b_s;
          rem = op_s[2] ? 34 : 1;
        end
        if (pend && !unit_hang) begin
          rem--;
          if (rem == 0) begin
            chk("md_opcode_hold", {29'd0, md_opcode}, {29'd0, op_l});
            chk("md_rs1_hold", md_rs1, a_l);
            chk("md_rs2_hold", md_rs2, b_l);
            md_ready = 1'b1;
            md_result = rv32m(op_l, a_l, b_l);
            pend = 1'b0; m_busy = 1'b0;
          end
        end
      end
    end
  end

  // Monitor: every writeback must match the next expected entry.
  always @(negedge clk) begin
    if (rst_n && wb_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_wb: got rd=%0d data=%h expected none", wb_rd, wb_data);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        chk("wb_rd", {27'd0, wb_rd}, {27'd0, e[36:32]});
        chk("wb_data", wb_data, e[31:0]);
      end
    end
  end

  // Present one instruction in EX until it leaves (stall low) or is flushed at cycle flush_at.
  task automatic run_instr(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd, input int flush_at, input logic [31:0] expv);
    in_valid = 1'b1; in_funct3 = f3; in_rs1_val = a; in_rs2_val = b; in_rd = rd;
    if (flush_at < 0 && rd != 5'd0) exp_q.push_back({rd, expv});
    for (int c = 0; ; c++) begin
      if (c > 200) begin
        n_checks++;
        n_errors++;
        $display("FAIL instr_timeout: got stall=%b expected 0 within 200 cycles", stall);
        break;
      end
      flush = (c == flush_at);
      @(negedge clk);
      if (flush || !stall) begin
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    flush = 1'b0; in_valid = 1'b0;
    in_rs1_val = $urandom; in_rs2_val = $urandom;
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
    chk({tag, "_md_start"}, {31'd0, md_start}, 32'd0);
    chk({tag, "_md_opcode"}, {29'd0, md_opcode}, 32'd0);
    chk({tag, "_md_rs1"}, md_rs1, 32'd0);
    chk({tag, "_md_rs2"}, md_rs2, 32'd0);
    chk({tag, "_wb_valid"}, {31'd0, wb_valid}, 32'd0);
    chk({tag, "_wb_rd"}, {27'd0, wb_rd}, 32'd0);
    chk({tag, "_wb_data"}, wb_data, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
  endtask

  function automatic logic [31:0] pick_op();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    n_checks = 0; n_errors = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_funct3 = 3'd0; in_rs1_val = 32'd0;
    in_rs2_val = 32'd0; in_rd = 5'd0; flush = 1'b0; busy_force = 1'b0; unit_hang = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // MUL cycle-accurate timing: start at T1, writeback at T3.
    in_valid = 1'b1; in_funct3 = 3'd0; in_rs1_val = 32'd7; in_rs2_val = 32'hFFFF_FFFD; in_rd = 5'd5;
    exp_q.push_back({5'd5, 32'hFFFF_FFEB});
    @(negedge clk);
    chk("mul_t0_stall", {31'd0, stall}, 32'd1);
    chk("mul_t0_start", {31'd0, md_start}, 32'd0);
    @(posedge clk); #1; @(negedge clk);
    chk("mul_t1_start", {31'd0, md_start}, 32'd1);
    chk("mul_t1_stall", {31'd0, stall}, 32'd1);
    @(posedge clk); #1; @(negedge clk);
    chk("mul_t2_stall", {31'd0, stall}, 32'd1);
    chk("mul_t2_start", {31'd0, md_start}, 32'd0);
    @(posedge clk); #1; @(negedge clk);
    chk("mul_t3_stall", {31'd0, stall}, 32'd0);
    chk("mul_t3_wb_valid", {31'd0, wb_valid}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;

    run_instr(3'd4, 32'hFFFF_FFEC, 32'd3, 5'd9, -1, 32'hFFFF_FFFA);
    run_instr(3'd5, 32'h0000_1234, 32'd0, 5'd10, -1, 32'hFFFF_FFFF);
    run_instr(3'd7, 32'h0000_1234, 32'd0, 5'd11, -1, 32'h0000_1234);

    // DIV flushed five cycles into WAIT, then a MUL waits out the drain.
    run_instr(3'd4, 32'd100, 32'd7, 5'd12, 7, 32'd0);
    in_valid = 1'b1; in_funct3 = 3'd0; in_rs1_val = 32'd3; in_rs2_val = 32'd4; in_rd = 5'd13;
    @(negedge clk);
    chk("drain_stall", {31'd0, stall}, 32'd1);
    chk("drain_no_start", {31'd0, md_start}, 32'd0);
    @(posedge clk); #1;
    run_instr(3'd0, 32'd3, 32'd4, 5'd13, -1, 32'h0000_000C);

    run_instr(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, -1, 32'd0);

    // Unit busy blocks accept.
    busy_force = 1'b1;
    in_valid = 1'b1; in_funct3 = 3'd1; in_rs1_val = 32'd9; in_rs2_val = 32'd9; in_rd = 5'd14;
    repeat (3) begin
      @(negedge clk);
      chk("busy_no_start", {31'd0, md_start}, 32'd0);
      @(posedge clk); #1;
    end
    busy_force = 1'b0;
    run_instr(3'd1, 32'd9, 32'd9, 5'd14, -1, rv32m(3'd1, 32'd9, 32'd9));

    // Reset in the middle of a divide.
    in_valid = 1'b1; in_funct3 = 3'd6; in_rs1_val = 32'd55; in_rs2_val = 32'd6; in_rd = 5'd15;
    repeat (10) @(posedge clk);
    #1;
    in_valid = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_zero_outputs("midreset");
    @(posedge clk); #1;
    run_instr(3'd2, 32'hFFFF_FFFE, 32'd5, 5'd16, -1, rv32m(3'd2, 32'hFFFF_FFFE, 32'd5));

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      int          fa;
      f = 3'($urandom_range(0, 7)); a = pick_op(); b = pick_op(); rd = 5'($urandom_range(0, 31));
      fa = -1;
      if ($urandom_range(0, 3) == 0) fa = f[2] ? int'($urandom_range(0, 30)) : int'($urandom_range(0, 3));
      run_instr(f, a, b, rd, fa, rv32m(f, a, b));
      repeat ($urandom_range(0, 2)) begin
        in_funct3 = 3'($urandom);
        @(posedge clk); #1;
      end
    end

`ifdef MULDIV_TIMEOUT_EN
    // Unit never answers: watchdog fires 64 cycles after entering WAIT.
    repeat (40) @(posedge clk);
    #1;
    unit_hang = 1'b1;
    in_valid = 1'b1; in_funct3 = 3'd4; in_rs1_val = 32'd1; in_rs2_val = 32'd1; in_rd = 5'd17;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 1; k <= 65; k++) begin
      @(posedge clk); #1;
      if (k == 64) begin
        @(negedge clk);
        chk("tmo_err_before", {31'd0, err}, 32'd0);
      end
    end
    @(negedge clk);
    chk("tmo_err", {31'd0, err}, 32'd1);
    chk("tmo_stall", {31'd0, stall}, 32'd0);
    chk("tmo_wb_valid", {31'd0, wb_valid}, 32'd0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("tmo_err_sticky", {31'd0, err}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; unit_hang = 1'b0;
    @(negedge clk);
    chk("tmo_err_reset", {31'd0, err}, 32'd0);
`endif

    repeat (50) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    chk("final_err", {31'd0, err}, 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish by 2ms");
    $fatal(1, "global timeout");
  end

endmodule
`default_nettype wire
